pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit: PC register, next-PC source select and a hardware saved-PC stack for nested trap/interrupt entry and return.
- Sits between the control store (ld_pc, pc_sel) and the datapath (bus, address adder, vector generator).
- Generalises the fixed 16-bit PC mux: configurable width, step, reset vector and alignment; adds VECTOR and RETURN sources with stack push/pop and sticky error reporting.

Parameters:
- W, 16, PC and datapath width in bits.
- INC_STEP, 2, increment applied on INC source.
- RESET_PC, 0, PC value after reset (W bits).
- DEPTH, 4, saved-PC stack entries (>=1).
- ALIGN, 1, when 1, bit 0 of every loaded BUS/ADDER/VECTOR value is forced to 0.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ld_pc  in  1  load PC this cycle; when 0 nothing changes (errors included).
- pc_sel  in  3  source: 0 INC, 1 BUS, 2 ADDER, 3 VECTOR, 4 RETURN, 5-7 illegal.
- bus  in  W  PC value from data bus.
- adder  in  W  PC value from address adder.
- vector  in  W  trap/interrupt target address.
- err_clr  in  1  clears sticky error flags.
- pc  out  W  current PC.
- saved_top  out  W  top-of-stack value; 0 when empty.
- depth  out  clog2(DEPTH+1)  entries held.
- stk_full  out  1  depth == DEPTH.
- stk_empty  out  1  depth == 0.
- ovf_err  out  1  sticky: VECTOR attempted with stack full.
- unf_err  out  1  sticky: RETURN attempted with stack empty.
- sel_err  out  1  sticky: ld_pc with illegal pc_sel.

Behaviour:
- Reset (rst_n low at posedge): pc=RESET_PC, depth=0, stack entries zeroed, all error flags 0, stk_empty=1, stk_full=0. Reset wins over every other input.
- All outputs registered or decoded from registers; load takes effect 1 cycle after the qualifying edge; no combinational path from inputs to outputs.
- ld_pc=1 at posedge:
  - INC: pc <= (pc + INC_STEP) mod 2^W; wraps silently.
  - BUS: pc <= bus (ALIGN applied).
  - ADDER: pc <= adder (ALIGN applied).
  - VECTOR: pc <= vector (ALIGN applied); if not full, push current pc (pre-load value) and depth+1; if full, push dropped, stack unchanged, ovf_err <= 1, pc still loads vector.
  - RETURN: if not empty, pc <= saved_top, pop, depth-1; if empty, pc holds and unf_err <= 1.
  - 5-7: pc holds, stack unchanged, sel_err <= 1.
- Popped value is restored unmodified (ALIGN not reapplied).
- Stack is LIFO; saved_top reflects the entry written by the most recent unmatched push.
- err_clr=1 clears all three flags at posedge. A new error in the same cycle wins: that flag ends at 1 and the others clear.
- ld_pc=0: pc, stack and flags hold; err_clr still acts.
- Reset mid-nesting discards all stack contents.

Decomposition:
- Shared package pc_pkg: pc_sel encodings (PC_INC, PC_BUS, PC_ADDER, PC_VECTOR, PC_RETURN) and the default width constant, shared with the control decoder.
- One natural sub-module: pc_stack (DEPTH x W LIFO with push, pop, top, depth, full and empty). pc_unit holds the PC register, source mux, alignment and error logic.

Test Plan:
- Reset, then 3 cycles of ld_pc=1 with INC -> pc 0x0000, 0x0002, 0x0004, 0x0006. With W=16 and pc=0xFFFE, INC -> 0x0000.
- BUS load of 0x3001 with ALIGN=1 -> pc=0x3000. ADDER load of 0x1234 -> pc=0x1234. Same BUS load with ld_pc=0 -> pc unchanged.
- From pc=0x3000: VECTOR 0x0200, then VECTOR 0x0400 -> depth=2, saved_top=0x0200. RETURN -> pc=0x0200. RETURN -> pc=0x3000, stk_empty=1.
- DEPTH=4: five VECTOR loads -> fifth sets ovf_err, pc=fifth vector, depth=4, saved_top=fourth-pushed PC. RETURN on empty stack -> pc holds, unf_err=1.
- pc_sel=6 with ld_pc=1 -> pc holds, sel_err=1. err_clr alone -> all flags 0. err_clr together with a RETURN on empty stack -> unf_err=1, other flags 0.
- After two pushes, rst_n=0 for one cycle -> pc=RESET_PC, depth=0, saved_top=0, flags 0. Reset asserted together with ld_pc=1 and VECTOR -> reset wins.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared program-counter definitions: pc_sel source encodings and default width.
// The control decoder and the PC unit both import this package.
package pc_pkg;

    localparam int PC_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        PC_INC    = 3'd0,
        PC_BUS    = 3'd1,
        PC_ADDER  = 3'd2,
        PC_VECTOR = 3'd3,
        PC_RETURN = 3'd4
    } pc_sel_e;

endpackage

// File: rtl/pc_stack.sv
// DEPTH x W LIFO holding return PCs for nested trap/interrupt entry.
// A push while full or a pop while empty is ignored; the parent reports those cases.
module pc_stack
    import pc_pkg::*;
#(
    parameter int W     = PC_W_DEFAULT,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (DW'(i) == depth_q) begin
                    mem_d[i] = push_data;
                end
            end
            depth_d = depth_q + DW'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DW'(1);
        end
    end

    // The top entry sits one below the depth pointer; an empty stack reads as zero.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i + 1) == depth_q) begin
                top = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC source select, and a saved-PC stack.
// It also keeps sticky error flags for stack overflow, stack underflow and illegal selects.
module pc_unit
    import pc_pkg::*;
#(
    parameter int           W        = PC_W_DEFAULT,
    parameter int           INC_STEP = 2,
    parameter logic [W-1:0] RESET_PC = '0,
    parameter int           DEPTH    = 4,
    parameter int           ALIGN    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ld_pc,
    input  logic [2:0]                   pc_sel,
    input  logic [W-1:0]                 bus,
    input  logic [W-1:0]                 adder,
    input  logic [W-1:0]                 vector,
    input  logic                         err_clr,
    output logic [W-1:0]                 pc,
    output logic [W-1:0]                 saved_top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         stk_full,
    output logic                         stk_empty,
    output logic                         ovf_err,
    output logic                         unf_err,
    output logic                         sel_err
);

    logic [W-1:0] pc_q, pc_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic         sel_q, sel_d;
    logic         push, pop;
    logic         new_ovf, new_unf, new_sel;

    function automatic logic [W-1:0] align_f(input logic [W-1:0] v);
        return (ALIGN != 0) ? {v[W-1:1], 1'b0} : v;
    endfunction

    pc_stack #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q),
        .top       (saved_top),
        .depth     (depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_comb begin
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        new_sel = 1'b0;
        if (ld_pc) begin
            case (pc_sel_e'(pc_sel))
                PC_INC:   pc_d = pc_q + W'(INC_STEP);
                PC_BUS:   pc_d = align_f(bus);
                PC_ADDER: pc_d = align_f(adder);
                // The vector always loads; only the save of the old PC can be lost.
                PC_VECTOR: begin
                    pc_d = align_f(vector);
                    if (stk_full) begin
                        new_ovf = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                PC_RETURN: begin
                    if (stk_empty) begin
                        new_unf = 1'b1;
                    end else begin
                        pc_d = saved_top;
                        pop  = 1'b1;
                    end
                end
                default: new_sel = 1'b1;
            endcase
        end
        // A fresh error beats a simultaneous clear.
        ovf_d = (ovf_q & ~err_clr) | new_ovf;
        unf_d = (unf_q & ~err_clr) | new_unf;
        sel_d = (sel_q & ~err_clr) | new_sel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            sel_q <= sel_d;
        end
    end

    assign pc      = pc_q;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;
    assign sel_err = sel_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a vector table, a random INC/BUS/ADDER phase,
// and a scoreboard queue of expected register states popped after each edge.
module tb_pc_unit;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int EXP_W = W + W + DW + 3;
    localparam int NVEC  = 37;

    typedef struct {
        logic          rst_n;
        logic          ld;
        logic [2:0]    sel;
        logic [W-1:0]  bus;
        logic [W-1:0]  adder;
        logic [W-1:0]  vec;
        logic          clr;
        logic [W-1:0]  e_pc;
        logic [W-1:0]  e_top;
        logic [DW-1:0] e_depth;
        logic          e_ovf;
        logic          e_unf;
        logic          e_sel;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          ld_pc;
    logic [2:0]    pc_sel;
    logic [W-1:0]  bus;
    logic [W-1:0]  adder;
    logic [W-1:0]  vector;
    logic          err_clr;
    logic [W-1:0]  pc;
    logic [W-1:0]  saved_top;
    logic [DW-1:0] depth;
    logic          stk_full;
    logic          stk_empty;
    logic          ovf_err;
    logic          unf_err;
    logic          sel_err;

    logic [EXP_W-1:0] exp_q[$];
    vec_t             vecs[NVEC];
    int               checks;
    int               errors;

    pc_unit #(
        .W        (W),
        .INC_STEP (2),
        .RESET_PC (16'h0000),
        .DEPTH    (DEPTH),
        .ALIGN    (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_pc     (ld_pc),
        .pc_sel    (pc_sel),
        .bus       (bus),
        .adder     (adder),
        .vector    (vector),
        .err_clr   (err_clr),
        .pc        (pc),
        .saved_top (saved_top),
        .depth     (depth),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err),
        .sel_err   (sel_err)
    );

    // Clock and reset-free idle drive
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic r, input logic ld, input logic [2:0] s,
                                input logic [W-1:0] b, input logic [W-1:0] a,
                                input logic [W-1:0] v, input logic c,
                                input logic [W-1:0] epc, input logic [W-1:0] etop,
                                input int ed, input logic eo, input logic eu,
                                input logic es);
        vec_t t;
        t.rst_n = r;   t.ld = ld;     t.sel = s;  t.bus = b; t.adder = a;
        t.vec = v;     t.clr = c;     t.e_pc = epc; t.e_top = etop;
        t.e_depth = DW'(ed); t.e_ovf = eo; t.e_unf = eu; t.e_sel = es;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Driver: inputs change on the falling edge, expectation enters the scoreboard.
    task automatic apply(input vec_t t);
        @(negedge clk);
        rst_n   = t.rst_n;
        ld_pc   = t.ld;
        pc_sel  = t.sel;
        bus     = t.bus;
        adder   = t.adder;
        vector  = t.vec;
        err_clr = t.clr;
        exp_q.push_back({t.e_pc, t.e_top, t.e_depth, t.e_ovf, t.e_unf, t.e_sel});
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_out();
        logic [EXP_W-1:0] e;
        logic [W-1:0]     e_pc, e_top;
        logic [DW-1:0]    e_d;
        logic             e_o, e_u, e_s;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty, got 1 expected 0 outputs");
            return;
        end
        e = exp_q.pop_front();
        {e_pc, e_top, e_d, e_o, e_u, e_s} = e;
        cmp("pc", pc, e_pc);
        cmp("saved_top", saved_top, e_top);
        cmp("depth", W'(depth), W'(e_d));
        cmp("stk_full", W'(stk_full), W'(e_d == DW'(DEPTH)));
        cmp("stk_empty", W'(stk_empty), W'(e_d == '0));
        cmp("ovf_err", W'(ovf_err), W'(e_o));
        cmp("unf_err", W'(unf_err), W'(e_u));
        cmp("sel_err", W'(sel_err), W'(e_s));
    endtask

    initial begin
        logic [W-1:0] model_pc;
        int           s;
        logic [W-1:0] v;

        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        ld_pc   = 1'b0;
        pc_sel  = 3'd0;
        bus     = '0;
        adder   = '0;
        vector  = '0;
        err_clr = 1'b0;

        //            rst ld sel bus      adder    vec      clr  pc       top      d  o  u  s
        vecs[0]  = mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0002, 16'h0000, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0004, 16'h0000, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0006, 16'h0000, 0, 0, 0, 0);
        vecs[4]  = mk(1, 1, 1, 16'hFFFE, 16'h0,    16'h0,    0, 16'hFFFE, 16'h0000, 0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 1, 16'h3001, 16'h0,    16'h0,    0, 16'h3000, 16'h0000, 0, 0, 0, 0);
        vecs[7]  = mk(1, 1, 2, 16'h0,    16'h1234, 16'h0,    0, 16'h1234, 16'h0000, 0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 1, 16'h3001, 16'h0,    16'h0,    0, 16'h1234, 16'h0000, 0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 1, 16'h3000, 16'h0,    16'h0,    0, 16'h3000, 16'h0000, 0, 0, 0, 0);
        vecs[10] = mk(1, 1, 3, 16'h0,    16'h0,    16'h0200, 0, 16'h0200, 16'h3000, 1, 0, 0, 0);
        vecs[11] = mk(1, 1, 3, 16'h0,    16'h0,    16'h0400, 0, 16'h0400, 16'h0200, 2, 0, 0, 0);
        vecs[12] = mk(1, 1, 4, 16'h0,    16'h0,    16'h0,    0, 16'h0200, 16'h3000, 1, 0, 0, 0);
        vecs[13] = mk(1, 1, 4, 16'h0,    16'h0,    16'h0,    0, 16'h3000, 16'h0000, 0, 0, 0, 0);
        vecs[14] = mk(1, 1, 3, 16'h0,    16'h0,    16'h0101, 0, 16'h0100, 16'h3000, 1, 0, 0, 0);
        vecs[15] = mk(1, 1, 3, 16'h0,    16'h0,    16'h0200, 0, 16'h0200, 16'h0100, 2, 0, 0, 0);
        vecs[16] = mk(1, 1, 3, 16'h0,    16'h0,    16'h0300, 0, 16'h0300, 16'h0200, 3, 0, 0, 0);
        vecs[17] = mk(1, 1, 3, 16'h0,    16'h0,    16'h0400, 0, 16'h0400, 16'h0300, 4, 0, 0, 0);
        vecs[18] = mk(1, 1, 3, 16'h0,    16'h0,    16'h0500, 0, 16'h0500, 16'h0300, 4, 1, 0, 0);
        vecs[19] = mk(1, 1, 4, 16'h0,    16'h0,    16'h0,    0, 16'h0300, 16'h0200, 3, 1, 0, 0);
        vecs[20] = mk(1, 1, 4, 16'h0,    16'h0,    16'h0,    0, 16'h0200, 16'h0100, 2, 1, 0, 0);
        vecs[21] = mk(1, 1, 4, 16'h0,    16'h0,    16'h0,    0, 16'h0100, 16'h3000, 1, 1, 0, 0);
        vecs[22] = mk(1, 1, 4, 16'h0,    16'h0,    16'h0,    0, 16'h3000, 16'h0000, 0, 1, 0, 0);
        vecs[23] = mk(1, 1, 4, 16'h0,    16'h0,    16'h0,    0, 16'h3000, 16'h0000, 0, 1, 1, 0);
        vecs[24] = mk(1, 1, 6, 16'h0,    16'h0,    16'h0,    0, 16'h3000, 16'h0000, 0, 1, 1, 1);
        vecs[25] = mk(1, 0, 0, 16'h0,    16'h0,    16'h0,    1, 16'h3000, 16'h0000, 0, 0, 0, 0);
        vecs[26] = mk(1, 1, 7, 16'h0,    16'h0,    16'h0,    0, 16'h3000, 16'h0000, 0, 0, 0, 1);
        vecs[27] = mk(1, 1, 4, 16'h0,    16'h0,    16'h0,    1, 16'h3000, 16'h0000, 0, 0, 1, 0);
        vecs[28] = mk(1, 0, 0, 16'h0,    16'h0,    16'h0,    1, 16'h3000, 16'h0000, 0, 0, 0, 0);
        vecs[29] = mk(1, 1, 3, 16'h0,    16'h0,    16'h0600, 0, 16'h0600, 16'h3000, 1, 0, 0, 0);
        vecs[30] = mk(1, 1, 3, 16'h0,    16'h0,    16'h0700, 0, 16'h0700, 16'h0600, 2, 0, 0, 0);
        vecs[31] = mk(1, 1, 5, 16'h0,    16'h0,    16'h0,    0, 16'h0700, 16'h0600, 2, 0, 0, 1);
        vecs[32] = mk(0, 0, 0, 16'h0,    16'h0,    16'h0,    0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        vecs[33] = mk(0, 1, 3, 16'h0,    16'h0,    16'h0800, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        vecs[34] = mk(1, 1, 3, 16'h0,    16'h0,    16'h0802, 0, 16'h0802, 16'h0000, 1, 0, 0, 0);
        vecs[35] = mk(1, 1, 4, 16'h0,    16'h0,    16'h0,    0, 16'h0000, 16'h0000, 0, 0, 0, 0);
        vecs[36] = mk(1, 0, 3, 16'h0,    16'h0,    16'h0900, 0, 16'h0000, 16'h0000, 0, 0, 0, 0);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
        end

        // Multi-cycle ramp from reset: two increments held back by ld_pc=0 in between.
        apply(mk(0, 1, 3, 16'h0, 16'h0, 16'h0A00, 1, 16'h0000, 16'h0000, 0, 0, 0, 0));
        apply(mk(1, 1, 0, 16'h0, 16'h0, 16'h0,    0, 16'h0002, 16'h0000, 0, 0, 0, 0));
        apply(mk(1, 0, 0, 16'h0, 16'h0, 16'h0,    0, 16'h0002, 16'h0000, 0, 0, 0, 0));
        apply(mk(1, 1, 0, 16'h0, 16'h0, 16'h0,    0, 16'h0004, 16'h0000, 0, 0, 0, 0));

        // Random INC/BUS/ADDER loads against a plain arithmetic model.
        model_pc = 16'h0004;
        for (int k = 0; k < 40; k++) begin
            s = $urandom_range(0, 2);
            v = W'($urandom_range(0, 16'hFFFF));
            if (s == 0) begin
                model_pc = model_pc + 16'd2;
            end else begin
                model_pc = v & 16'hFFFE;
            end
            apply(mk(1, 1, 3'(s), v, v, 16'h0, 0, model_pc, 16'h0000, 0, 0, 0, 0));
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
